logic_op_decoder: RTL and testbench

LOGIC_OP_DECODER -- requirements
Module: logic_op_decoder

---
 rtl/logic_op_decoder_pkg.sv | 34 +++
 rtl/logic_op_decoder_funct.sv | 68 ++++++
 rtl/logic_op_decoder.sv | 123 ++++++++++++
 tb/tb_logic_op_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_decoder_pkg.sv
`default_nettype none
// =============================================================================
// Module   : logic_op_decoder_pkg
// Brief    : Shared CPU constants: MIPS logical opcodes/functs, logical-unit
//            op encodings and skid-buffer state encodings.
// Revision : 1.0 - initial release
// =============================================================================
package logic_op_decoder_pkg;

    localparam logic [5:0] C_OPC_RTYPE = 6'h00;
    localparam logic [5:0] C_OPC_ANDI  = 6'h0C;
    localparam logic [5:0] C_OPC_ORI   = 6'h0D;
    localparam logic [5:0] C_OPC_XORI  = 6'h0E;

    localparam logic [5:0] C_FN_AND = 6'h24;
    localparam logic [5:0] C_FN_OR  = 6'h25;
    localparam logic [5:0] C_FN_XOR = 6'h26;
    localparam logic [5:0] C_FN_NOR = 6'h27;

    typedef enum logic [1:0] {
        LOP_AND = 2'b00,
        LOP_OR  = 2'b01,
        LOP_XOR = 2'b10,
        LOP_NOR = 2'b11
    } lop_e;

    localparam logic [1:0] C_ST_EMPTY = 2'd0;
    localparam logic [1:0] C_ST_ONE   = 2'd1;
    localparam logic [1:0] C_ST_FULL  = 2'd2;

    localparam logic [7:0] C_ILL_CNT_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/logic_op_decoder_funct.sv
`default_nettype none
// =============================================================================
// Module   : logic_funct_decode
// Brief    : Combinational decode of MIPS AND/OR/XOR/NOR/ANDI/ORI/XORI into
//            logical-unit operands, op select and destination register.
// Revision : 1.0 - initial release
// =============================================================================
module logic_funct_decode
    import logic_op_decoder_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [31:0]  instr_i,
    input  logic [N-1:0] rs_data_i,
    input  logic [N-1:0] rt_data_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [1:0]   op_o,
    output logic [4:0]   dest_o,
    output logic         illegal_o
);

    logic [N-1:0] w_imm;
    logic         w_unused_shamt;

    assign w_unused_shamt = ^instr_i[10:6];

    generate
        if (N > 16) begin : g_imm_ext
            assign w_imm = {{(N-16){1'b0}}, instr_i[15:0]};
        end else if (N == 16) begin : g_imm_exact
            assign w_imm = instr_i[15:0];
        end else begin : g_imm_trunc
            assign w_imm = instr_i[N-1:0];
        end
    endgenerate

    // Anything not matched falls through as an illegal bundle with zeroed fields.
    always_comb begin
        a_o       = '0;
        b_o       = '0;
        op_o      = LOP_AND;
        dest_o    = 5'd0;
        illegal_o = 1'b1;
        case (instr_i[31:26])
            C_OPC_RTYPE: begin
                if (instr_i[5:0] == C_FN_AND || instr_i[5:0] == C_FN_OR ||
                    instr_i[5:0] == C_FN_XOR || instr_i[5:0] == C_FN_NOR) begin
                    a_o       = rs_data_i;
                    b_o       = rt_data_i;
                    op_o      = instr_i[1:0];
                    dest_o    = instr_i[15:11];
                    illegal_o = 1'b0;
                end
            end
            C_OPC_ANDI, C_OPC_ORI, C_OPC_XORI: begin
                a_o       = rs_data_i;
                b_o       = w_imm;
                op_o      = instr_i[27:26];
                dest_o    = instr_i[20:16];
                illegal_o = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_op_decoder.sv
`default_nettype none
// =============================================================================
// Module   : logic_op_decoder
// Brief    : Decodes logical instructions through a 2-entry skid buffer toward
//            the logical unit and counts illegal bundles.
// Revision : 1.0 - initial release
// =============================================================================
module logic_op_decoder
    import logic_op_decoder_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] rt_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [1:0]   op,
    output logic [4:0]   dest,
    output logic         illegal,
    output logic [7:0]   illegal_count
);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   op;
        logic [4:0]   dest;
        logic         ill;
    } bundle_t;

    bundle_t    w_dec;
    bundle_t    head_q, head_d;
    bundle_t    skid_q, skid_d;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       w_in_xfer;
    logic       w_out_xfer;

    logic_funct_decode #(.N(N)) u_decode (
        .instr_i   (instr),
        .rs_data_i (rs_data),
        .rt_data_i (rt_data),
        .a_o       (w_dec.a),
        .b_o       (w_dec.b),
        .op_o      (w_dec.op),
        .dest_o    (w_dec.dest),
        .illegal_o (w_dec.ill)
    );

    assign in_ready   = (state_q != C_ST_FULL);
    assign out_valid  = (state_q != C_ST_EMPTY);
    assign w_in_xfer  = in_valid & in_ready & ~flush;
    assign w_out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        case (state_q)
            C_ST_EMPTY: begin
                if (w_in_xfer) begin
                    head_d  = w_dec;
                    state_d = C_ST_ONE;
                end
            end
            C_ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    head_d = w_dec;
                end else if (w_in_xfer) begin
                    skid_d  = w_dec;
                    state_d = C_ST_FULL;
                end else if (w_out_xfer) begin
                    state_d = C_ST_EMPTY;
                end
            end
            C_ST_FULL: begin
                if (w_out_xfer) begin
                    head_d  = skid_q;
                    state_d = C_ST_ONE;
                end
            end
            default: state_d = C_ST_EMPTY;
        endcase
        if (flush) begin
            state_d = C_ST_EMPTY;
        end
        if (w_in_xfer && w_dec.ill && cnt_q != C_ILL_CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A             = head_q.a;
    assign B             = head_q.b;
    assign op            = head_q.op;
    assign dest          = head_q.dest;
    assign illegal       = head_q.ill;
    assign illegal_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_decoder.sv
`default_nettype none
// =============================================================================
// Module   : tb_logic_op_decoder
// Brief    : Self-checking bench for logic_op_decoder (vector table + sequences).
// Revision : 1.0 - initial release
// =============================================================================
module tb_logic_op_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  op;
    logic [4:0]  dest;
    logic        illegal;
    logic [7:0]  illegal_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  dest;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    logic_op_decoder #(.N(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .A             (A),
        .B             (B),
        .op            (op),
        .dest          (dest),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        instr   = v.instr;
        rs_data = v.rs;
        rt_data = v.rt;
    endtask

    function automatic int sat_inc(input int c);
        return (c < 255) ? c + 1 : 255;
    endfunction

    // Streams cnt table vectors starting at 'first'; out_ready held low for 'stall' cycles.
    task automatic run_stream(input int first, input int cnt, input int stall);
        int sent = 0;
        int rcvd = 0;
        int q[$];
        int idx;
        for (int c = 0; c < 200 && rcvd < cnt; c++) begin
            @(negedge clk);
            in_valid = (sent < cnt);
            if (sent < cnt) drive(vecs[first + sent]);
            out_ready = (c >= stall);
            if (c == 2 && stall >= 3 && cnt >= 3) chk("in_ready_after_two", in_ready, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    idx = q.pop_front();
                    chk("stream_bundle", {A, B, op, dest, illegal},
                        {vecs[idx].a, vecs[idx].b, vecs[idx].op, vecs[idx].dest, vecs[idx].ill});
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                q.push_back(first + sent);
                if (vecs[first + sent].ill) exp_cnt = sat_inc(exp_cnt);
                sent++;
            end
        end
        if (rcvd < cnt) chk("stream_timeout", rcvd, cnt);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream_drained", out_valid, 0);
        chk("stream_count", illegal_count, exp_cnt);
    endtask

    // Two bundles with out_ready low leaves the buffer FULL at the following negedge.
    task automatic fill_full();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[1]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
    endtask

    initial begin
        vecs[0] = '{32'h00A63024, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 5'd6,  1'b0};
        vecs[1] = '{32'h00221825, 32'h0000FFFF, 32'h12345678, 32'h0000FFFF, 32'h12345678, 2'b01, 5'd3,  1'b0};
        vecs[2] = '{32'h0000F826, 32'hAAAA5555, 32'h0F0F0F0F, 32'hAAAA5555, 32'h0F0F0F0F, 2'b10, 5'd31, 1'b0};
        vecs[3] = '{32'h00000027, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 2'b11, 5'd0,  1'b0};
        vecs[4] = '{32'h3445ABCD, 32'h12340000, 32'hDEADBEEF, 32'h12340000, 32'h0000ABCD, 2'b01, 5'd5,  1'b0};
        vecs[5] = '{32'h3000FFFF, 32'h87654321, 32'hDEADBEEF, 32'h87654321, 32'h0000FFFF, 2'b00, 5'd0,  1'b0};
        vecs[6] = '{32'h39F01234, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00001234, 2'b10, 5'd16, 1'b0};
        vecs[7] = '{32'h8C000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 2'b00, 5'd0,  1'b1};
        vecs[8] = '{32'h00221820, 32'h55555555, 32'h66666666, 32'h00000000, 32'h00000000, 2'b00, 5'd0,  1'b1};
        vecs[9] = '{32'h3C011234, 32'h77777777, 32'h88888888, 32'h00000000, 32'h00000000, 2'b00, 5'd0,  1'b1};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {out_valid, A, B, op, dest, illegal, illegal_count}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        // Single bundles, one per vector, latency one cycle.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (vecs[i].ill) exp_cnt = sat_inc(exp_cnt);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_fields", i), {A, B, op, dest, illegal},
                {vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].dest, vecs[i].ill});
            chk($sformatf("vec%0d_count", i), illegal_count, exp_cnt);
        end
        @(negedge clk);
        chk("idle_after_table", out_valid, 0);

        run_stream(0, 3, 4);
        run_stream(3, 7, 0);
        run_stream(4, 5, 2);

        // Flush while FULL with a same-cycle illegal input that must be ignored.
        fill_full();
        flush    = 1'b1;
        in_valid = 1'b1;
        drive(vecs[7]);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_count", illegal_count, exp_cnt);
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_no_output", out_valid, 0);

        // Asynchronous reset between edges while FULL.
        fill_full();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_fields", {A, B, op, dest, illegal, illegal_count}, '0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("async_rst_ready", in_ready, 1);
        chk("async_rst_no_output", out_valid, 0);

        // Saturation of the illegal counter.
        in_valid = 1'b1;
        drive(vecs[7]);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) exp_cnt = sat_inc(exp_cnt);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("count_saturated", illegal_count, 255);
        chk("count_model", illegal_count, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
